// File: rtl/d8m_tx_pkg.sv
// Shared types and constants for the d8m_pattern_tx raw Bayer test-frame source.
// Optional build macro D8M_TX_LFSR_EN turns pattern 3 into LFSR noise.
package d8m_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEAD   = 3'd1,
        ST_LINE   = 3'd2,
        ST_HBLANK = 3'd3,
        ST_GAP    = 3'd4
    } state_e;

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_RAMP  = 2'd1;
    localparam logic [1:0] PAT_GREY  = 2'd2;
    localparam logic [1:0] PAT_CHECK = 2'd3;

    // {R,G,B} on/off flags per bar; element 0 is the leftmost (white) bar.
    localparam logic [7:0][2:0] BAR_TABLE = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    localparam logic [9:0] GREY_LEVEL = 10'h200;
    localparam logic [9:0] CHAN_FULL  = 10'h3FF;

    localparam logic [9:0] LFSR_SEED  = 10'h001;
    localparam int         LFSR_TAP_A = 9;
    localparam int         LFSR_TAP_B = 6;

endpackage

// File: rtl/d8m_tx_pixgen.sv
// Maps (x, y, pattern) to the RGGB Bayer sample for one pixel.
// With D8M_TX_LFSR_EN defined, pattern 3 emits a x^10+x^7+1 LFSR held here.
module d8m_tx_pixgen
    import d8m_tx_pkg::*;
#(
    parameter int H_ACTIVE = 640
) (
`ifdef D8M_TX_LFSR_EN
    input  logic       clk,
    input  logic       rst,
    input  logic       lfsr_load,
    input  logic       lfsr_step,
`endif
    input  logic [10:0] x,
    input  logic        row_odd,
    input  logic        row_blk,
    input  logic [1:0]  pattern,
    output logic [9:0]  pix
);

    localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

    logic [2:0] bar;
    logic [2:0] rgb;
    logic [9:0] r_ch;
    logic [9:0] g_ch;
    logic [9:0] b_ch;
    logic [9:0] bayer;

`ifdef D8M_TX_LFSR_EN
    logic [9:0] lfsr_q;
    logic [9:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (lfsr_load) begin
            lfsr_d = LFSR_SEED;
        end else if (lfsr_step) begin
            lfsr_d = {lfsr_q[8:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= lfsr_d;
    end
`endif

    always_comb begin
        bar  = 3'(x / BAR_W);
        rgb  = BAR_TABLE[bar];
        r_ch = '0;
        g_ch = '0;
        b_ch = '0;
        case (pattern)
            PAT_BARS: begin
                r_ch = {10{rgb[2]}};
                g_ch = {10{rgb[1]}};
                b_ch = {10{rgb[0]}};
            end
            PAT_RAMP: begin
                r_ch = x[9:0];
                g_ch = x[9:0];
                b_ch = x[9:0];
            end
            PAT_GREY: begin
                r_ch = GREY_LEVEL;
                g_ch = GREY_LEVEL;
                b_ch = GREY_LEVEL;
            end
            default: begin
                r_ch = {10{x[5] ^ row_blk}};
                g_ch = r_ch;
                b_ch = r_ch;
            end
        endcase

        // RGGB: even rows alternate R/G, odd rows alternate G/B.
        case ({row_odd, x[0]})
            2'b00:   bayer = r_ch;
            2'b01:   bayer = g_ch;
            2'b10:   bayer = g_ch;
            default: bayer = b_ch;
        endcase

        pix = bayer;
`ifdef D8M_TX_LFSR_EN
        if (pattern == PAT_CHECK) pix = lfsr_q;
`endif
    end

endmodule

// File: rtl/d8m_pattern_tx.sv
// Raw Bayer test-frame source on the 10-bit pixel / LVAL / FVAL camera interface.
// Build macro D8M_TX_LFSR_EN selects LFSR noise instead of checkerboard for pattern 3.
module d8m_pattern_tx
    import d8m_tx_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int V_LEAD   = 16,
    parameter int F_GAP    = 1600
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iEN,
    input  logic [1:0]  iPATTERN,
    output logic [9:0]  oPIXEL_D,
    output logic        oPIXEL_HS,
    output logic        oPIXEL_VS,
    output logic        oFRAME_DONE,
    output logic [15:0] oFRAME_CNT,
    output logic        oBUSY,
    output state_e      dbg_state
);

    localparam logic [10:0] X_LAST    = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_LAST    = 11'(V_ACTIVE - 1);
    localparam logic [15:0] LEAD_LAST = 16'(V_LEAD - 1);
    localparam logic [15:0] HB_LAST   = 16'(H_BLANK - 1);
    localparam logic [15:0] GAP_LAST  = 16'(F_GAP - 1);

    state_e      state_q, state_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  pat_q, pat_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic [9:0]  pix_q, pix_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic [9:0]  pix_val;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        fcnt_d  = fcnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iEN) begin
                    state_d = ST_LEAD;
                    pat_d   = iPATTERN;
                    x_d     = '0;
                    y_d     = '0;
                    cnt_d   = '0;
                end
            end
            ST_LEAD: begin
                if (cnt_q == LEAD_LAST) begin
                    state_d = ST_LINE;
                    cnt_d   = '0;
                    x_d     = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_LINE: begin
                if (x_q == X_LAST) begin
                    state_d = ST_HBLANK;
                    cnt_d   = '0;
                end else begin
                    x_d = x_q + 11'd1;
                end
            end
            ST_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    cnt_d = '0;
                    if (y_q == Y_LAST) begin
                        state_d = ST_GAP;
                        done_d  = 1'b1;
                        fcnt_d  = fcnt_q + 16'd1;
                    end else begin
                        state_d = ST_LINE;
                        y_d     = y_q + 11'd1;
                        x_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (iEN) begin
                        state_d = ST_LEAD;
                        pat_d   = iPATTERN;
                        x_d     = '0;
                        y_d     = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so every output is a flop
        // and the pixel lands in the same cycle as its HS.
        hs_d   = (state_d == ST_LINE);
        vs_d   = (state_d == ST_LEAD) || (state_d == ST_LINE) || (state_d == ST_HBLANK);
        busy_d = (state_d != ST_IDLE);
        pix_d  = hs_d ? pix_val : '0;
    end

    d8m_tx_pixgen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pixgen (
`ifdef D8M_TX_LFSR_EN
        .clk       (iCLK),
        .rst       (iRST),
        .lfsr_load ((state_d == ST_LEAD) && (state_q != ST_LEAD)),
        .lfsr_step (hs_d),
`endif
        .x         (x_d),
        .row_odd   (y_d[0]),
        .row_blk   (y_d[5]),
        .pattern   (pat_d),
        .pix       (pix_val)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            pat_q   <= '0;
            fcnt_q  <= '0;
            pix_q   <= '0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            fcnt_q  <= fcnt_d;
            pix_q   <= pix_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign oPIXEL_D    = pix_q;
    assign oPIXEL_HS   = hs_q;
    assign oPIXEL_VS   = vs_q;
    assign oFRAME_DONE = done_q;
    assign oFRAME_CNT  = fcnt_q;
    assign oBUSY       = busy_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_d8m_pattern_tx.sv
// Scoreboard bench for d8m_pattern_tx on a reduced frame geometry.
// Pixel streams come from a per-pixel pattern model; frame timing from closed-form lengths.
module tb_d8m_pattern_tx;
    import d8m_tx_pkg::*;

    localparam int HA      = 64;
    localparam int HB      = 4;
    localparam int VA      = 34;
    localparam int VL      = 3;
    localparam int FG      = 7;
    localparam int LINE_P  = HA + HB;
    localparam int VS_LEN  = VL + VA * LINE_P;
    localparam int FRAME_P = VS_LEN + FG;
    localparam int DROP_AT = VL + 10 * LINE_P + 5;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic [1:0] pattern = 2'd0;

    always #5 clk = ~clk;

    logic [9:0]  pix;
    logic        hs;
    logic        vs;
    logic        done;
    logic [15:0] fcnt;
    logic        busy;
    state_e      dbg_state;

    d8m_pattern_tx #(
        .H_ACTIVE (HA),
        .H_BLANK  (HB),
        .V_ACTIVE (VA),
        .V_LEAD   (VL),
        .F_GAP    (FG)
    ) dut (
        .iCLK        (clk),
        .iRST        (rst),
        .iEN         (en),
        .iPATTERN    (pattern),
        .oPIXEL_D    (pix),
        .oPIXEL_HS   (hs),
        .oPIXEL_VS   (vs),
        .oFRAME_DONE (done),
        .oFRAME_CNT  (fcnt),
        .oBUSY       (busy),
        .dbg_state   (dbg_state)
    );

    // scoreboard state
    logic [9:0]  exp_q[$];
    logic [15:0] exp_frame_q[$];
    int vectors      = 0;
    int miscompares  = 0;
    int model_frames = 0;
    bit mon_hold     = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference pixel: colour from the pattern rules, then RGGB site select.
    function automatic logic [9:0] model_pix(input int pat, input int x, input int y);
        int r, g, b, bar;
        r = 0; g = 0; b = 0;
        case (pat)
            0: begin
                bar = x / (HA / 8);  // white yellow cyan green magenta red blue black
                r = (bar == 0 || bar == 1 || bar == 4 || bar == 5) ? 1023 : 0;
                g = (bar <= 3) ? 1023 : 0;
                b = (bar == 0 || bar == 2 || bar == 4 || bar == 6) ? 1023 : 0;
            end
            1: begin r = x % 1024; g = r; b = r; end
            2: begin r = 512; g = 512; b = 512; end
            default: begin
                r = (((x / 32) % 2) != ((y / 32) % 2)) ? 1023 : 0;
                g = r; b = r;
            end
        endcase
        if (y % 2 == 0) return 10'((x % 2 == 0) ? r : g);
        else            return 10'((x % 2 == 0) ? g : b);
    endfunction

    // driver tasks
    task automatic push_frame(input logic [1:0] pat);
        int lfsr;
        lfsr = 1;
        for (int y = 0; y < VA; y++) begin
            for (int x = 0; x < HA; x++) begin
`ifdef D8M_TX_LFSR_EN
                if (pat == 2'd3) begin
                    exp_q.push_back(10'(lfsr));
                    lfsr = ((lfsr * 2) % 1024) + (((lfsr / 512) + (lfsr / 64)) % 2);
                end else begin
                    exp_q.push_back(model_pix(int'(pat), x, y));
                end
`else
                exp_q.push_back(model_pix(int'(pat), x, y));
`endif
            end
        end
        model_frames++;
        exp_frame_q.push_back(16'(model_frames));
    endtask

    // Called one posedge+1 before the edge that latches iEN/iPATTERN (= pat).
    task automatic play_frame(input logic [1:0] pat, input logic [1:0] next_pat,
                              input bit en_after, input bit from_idle);
        push_frame(pat);
        if (from_idle) begin
            @(negedge clk);
            check("vs_before_start", 32'(vs), 32'd0);
            @(negedge clk);
            check("vs_rise_latency", 32'(vs), 32'd1);
        end
        for (int k = (from_idle ? 1 : 0); k < FRAME_P; k++) begin
            @(posedge clk); #1;
            if (k == DROP_AT) begin
                en      = en_after;
                pattern = next_pat;
            end else if (k < DROP_AT && (k % 37) == 0) begin
                pattern = 2'($urandom_range(0, 3));
            end
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_vs"},    32'(vs), 32'd0);
        check({tag, "_hs"},    32'(hs), 32'd0);
        check({tag, "_pix"},   32'(pix), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
        check({tag, "_fcnt"},  32'(fcnt), 32'(16'(model_frames)));
    endtask

    // monitor
    initial begin : monitor
        bit vs_prev, hs_prev, in_gap;
        int vs_run, hs_run, gap_run, lines;
        logic [9:0]  e;
        logic [15:0] fe;
        vs_prev = 0; hs_prev = 0; in_gap = 0;
        vs_run = 0; hs_run = 0; gap_run = 0; lines = 0;
        forever begin
            @(negedge clk);
            if (mon_hold) begin
                vs_prev = 0; hs_prev = 0; in_gap = 0;
                vs_run = 0; hs_run = 0; gap_run = 0; lines = 0;
            end else begin
                if (in_gap && (vs || !busy)) begin
                    check("gap_len", 32'(gap_run), 32'(FG));
                    in_gap = 0;
                end
                if (vs && !vs_prev) begin
                    vs_run = 0;
                    lines  = 0;
                    check("busy_at_vs_rise", 32'(busy), 32'd1);
                end
                if (hs && !hs_prev) begin
                    lines++;
                    if (lines == 1) check("lead_len", 32'(vs_run), 32'(VL));
                end
                if (!hs && hs_prev) begin
                    check("hs_width", 32'(hs_run), 32'(HA));
                    hs_run = 0;
                end
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        check("pixel_unexpected", 32'(hs), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel", 32'(pix), 32'(e));
                    end
                end else if (vs) begin
                    check("blank_data", 32'(pix), 32'd0);
                end
                if (!vs && vs_prev) begin
                    check("vs_len", 32'(vs_run), 32'(VS_LEN));
                    check("lines_per_frame", 32'(lines), 32'(VA));
                    check("frame_done_pulse", 32'(done), 32'd1);
                    if (exp_frame_q.size() == 0) begin
                        check("frame_unexpected", 32'(vs), 32'd1);
                    end else begin
                        fe = exp_frame_q.pop_front();
                        check("frame_cnt", 32'(fcnt), 32'(fe));
                    end
                    in_gap  = 1;
                    gap_run = 0;
                end else begin
                    check("frame_done_idle", 32'(done), 32'd0);
                end
                if (vs) vs_run++;
                if (hs) hs_run++;
                if (in_gap && !vs && busy) gap_run++;
                vs_prev = vs;
                hs_prev = hs;
            end
        end
    end

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    // stimulus
    initial begin
        logic [1:0] p;
        logic [1:0] q;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_hold = 1'b0;

        // directed: every pattern back to back, iEN dropped mid-way through the last
        pattern = 2'd0;
        en      = 1'b1;
        play_frame(2'd0, 2'd1, 1'b1, 1'b1);
        play_frame(2'd1, 2'd2, 1'b1, 1'b0);
        play_frame(2'd2, 2'd3, 1'b1, 1'b0);
        play_frame(2'd3, 2'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_idle("after_drop");

        // random patterns, restarted from idle
        @(posedge clk); #1;
        p       = 2'($urandom_range(0, 3));
        pattern = p;
        en      = 1'b1;
        for (int f = 0; f < 3; f++) begin
            q = 2'($urandom_range(0, 3));
            play_frame(p, q, (f < 2), (f == 0));
            p = q;
        end
        repeat (3) @(negedge clk);
        check_idle("after_random");

        // reset in the middle of line 20
        @(posedge clk); #1;
        pattern = 2'd1;
        en      = 1'b1;
        push_frame(2'd1);
        repeat (VL + 20 * LINE_P + 10) begin
            @(posedge clk); #1;
        end
        mon_hold = 1'b1;
        rst      = 1'b1;
        en       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        exp_frame_q.delete();
        model_frames = 0;
        check_idle("mid_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        mon_hold = 1'b0;

        // full frame after reset
        p       = 2'($urandom_range(0, 3));
        pattern = p;
        en      = 1'b1;
        play_frame(p, 2'd0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check_idle("final");
        check("pixels_left", 32'(exp_q.size()), 32'd0);
        check("frames_left", 32'(exp_frame_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
